branch_resolver: RTL

Resolution-side partner of the decode-stage branch predictor. It records each prediction issued at decode in an in-order queue and retires the oldest entry when the branch resolves at the memory stage. On retirement it compares predicted and actual direction, raises a one-cycle mispredict pulse with the corrected PC, and discards all younger wrong-path entries. It also returns a registered training strobe (valid + actual decision) that drives the predictor's `branch_mem_sig` / `actual_branch_decision` inputs.

---
 rtl/branch_resolver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of decode predictions retired at memory-stage resolution; outputs one cycle after res_valid.
// pred_ready drops while full or in RECOVER; optional statistics counters under `BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic [ADDR_W-1:0] pred_fallthru,
  output logic              pred_ready,
  input  logic              res_valid,
  input  logic              res_taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              update_valid,
  output logic              update_taken,
  output logic              empty,
  output logic              err,
  output logic [31:0]       resolved_count,
  output logic [31:0]       mispredict_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, TRACK, RECOVER} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mispredict_q, mispredict_d;
  logic [ADDR_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic               update_valid_q, update_valid_d;
  logic               update_taken_q, update_taken_d;
  logic               err_q, err_d;

  logic               ent_taken_q    [DEPTH];
  logic [ADDR_W-1:0]  ent_target_q   [DEPTH];
  logic [ADDR_W-1:0]  ent_fallthru_q [DEPTH];

  logic push, res_ok, mis;

  assign pred_ready = (count_q != FULL) && (state_q != RECOVER);
  assign push       = pred_valid & pred_ready;
  assign res_ok     = res_valid & (count_q != '0);
  assign mis        = res_ok & (res_taken != ent_taken_q[rd_ptr_q]);

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q + CNT_W'(push) - CNT_W'(res_ok);
    mispredict_d   = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    update_valid_d = res_ok;
    update_taken_d = res_ok & res_taken;
    // Drops during RECOVER are wrong-path instructions, not protocol errors.
    err_d          = (pred_valid & ~pred_ready & (state_q != RECOVER)) |
                     (res_valid & (count_q == '0));
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (res_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case (state_q)
      IDLE:    if (push) state_d = TRACK;
      TRACK:   if (count_d == '0) state_d = IDLE;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mis) begin
      state_d       = RECOVER;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      mispredict_d  = 1'b1;
      redirect_pc_d = res_taken ? ent_target_q[rd_ptr_q] : ent_fallthru_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
      update_valid_q <= 1'b0;
      update_taken_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
      update_valid_q <= update_valid_d;
      update_taken_q <= update_taken_d;
      err_q          <= err_d;
    end
  end

  // Entry storage needs no reset: pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_taken_q[wr_ptr_q]    <= pred_taken;
      ent_target_q[wr_ptr_q]   <= pred_target;
      ent_fallthru_q[wr_ptr_q] <= pred_fallthru;
    end
  end

  assign mispredict   = mispredict_q;
  assign redirect_pc  = redirect_pc_q;
  assign update_valid = update_valid_q;
  assign update_taken = update_taken_q;
  assign err          = err_q;
  assign empty        = (count_q == '0);

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] resolved_count_q, resolved_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    resolved_count_d   = resolved_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res_ok && (resolved_count_q != 32'hFFFF_FFFF))
      resolved_count_d = resolved_count_q + 32'd1;
    if (mis && (mispredict_count_q != 32'hFFFF_FFFF))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_count_q   <= '0;
      mispredict_count_q <= '0;
    end else begin
      resolved_count_q   <= resolved_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign resolved_count   = resolved_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign resolved_count   = '0;
  assign mispredict_count = '0;
`endif

endmodule
